// File: rtl/spi_tx_unpacker_pkg.sv
// Shared definitions for the SPI TX word-to-byte unpacker: transfer size
// encodings, FSM state type and the unit alignment helper.
package spi_tx_unpacker_pkg;

    localparam int UNPACK_WORD_W = 32;
    localparam int UNPACK_BYTE_W = 8;

    localparam logic [1:0] SPI_TRANS_8_BITS  = 2'b00;
    localparam logic [1:0] SPI_TRANS_16_BITS = 2'b01;
    localparam logic [1:0] SPI_TRANS_24_BITS = 2'b10;
    localparam logic [1:0] SPI_TRANS_32_BITS = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } unpack_state_e;

    // Place the unit so that its first byte sits where the output byte is
    // taken from: bits [7:0] for LSB-first, bits [31:24] for MSB-first.
    function automatic logic [UNPACK_WORD_W-1:0] align_unit(
        input logic [UNPACK_WORD_W-1:0] data,
        input logic [1:0]               dsize,
        input logic                     lsb
    );
        logic [UNPACK_WORD_W-1:0] res;
        res = data;
        if (!lsb) begin
            unique case (dsize)
                SPI_TRANS_8_BITS:  res = data << 24;
                SPI_TRANS_16_BITS: res = data << 16;
                SPI_TRANS_24_BITS: res = data << 8;
                default:           res = data;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_tx_unpacker.sv
// Splits one 8/16/24/32-bit unit written to TXR into a byte stream for the
// TX FIFO push port, MSB- or LSB-first, with drop detection on busy writes.
module spi_tx_unpacker
    import spi_tx_unpacker_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic [1:0]            dsize_i,
    input  logic                  lsb_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic [7:0]            byte_data_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    if (WORD_WIDTH != UNPACK_WORD_W) begin : g_bad_width
        $error("spi_tx_unpacker: only WORD_WIDTH=32 is supported");
    end

    unpack_state_e         state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [1:0]            rem_q, rem_d;
    logic                  lsb_q, lsb_d;
    logic                  ovf_q, ovf_d;

    logic byte_fire;
    logic last_fire;
    logic accept;

    assign byte_fire = (state_q == ST_SEND) && byte_ready_i;
    assign last_fire = byte_fire && (rem_q == 2'd0);

    // Ready depends combinationally on byte_ready_i so the next word can load
    // in the same cycle the last byte leaves.
    assign wr_ready_o = !flush_i && ((state_q == ST_IDLE) || last_fire);
    assign accept     = wr_valid_i && wr_ready_o;
    assign ovf_d      = wr_valid_i && !wr_ready_o && !flush_i;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rem_d   = rem_q;
        lsb_d   = lsb_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            word_d  = '0;
            rem_d   = 2'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_SEND;
                        word_d  = align_unit(wr_data_i, dsize_i, lsb_i);
                        rem_d   = dsize_i;
                        lsb_d   = lsb_i;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        state_d = ST_SEND;
                        word_d  = align_unit(wr_data_i, dsize_i, lsb_i);
                        rem_d   = dsize_i;
                        lsb_d   = lsb_i;
                    end else if (byte_fire) begin
                        if (rem_q != 2'd0) begin
                            word_d = lsb_q ? (word_q >> 8) : (word_q << 8);
                            rem_d  = rem_q - 2'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            rem_q   <= 2'd0;
            lsb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            lsb_q   <= lsb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign byte_valid_o = (state_q == ST_SEND);
    assign busy_o       = (state_q == ST_SEND);
    assign byte_data_o  = lsb_q ? word_q[7:0] : word_q[WORD_WIDTH-1 -: 8];
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_spi_tx_unpacker.sv
// Bench for spi_tx_unpacker: directed cases plus random traffic, checked
// every cycle against a queue-of-pending-bytes reference model.
module tb_spi_tx_unpacker;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  dsize_i = 2'b00;
    logic        lsb_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [31:0] wr_data_i = '0;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic [7:0]  byte_data_o;
    logic        busy_o;
    logic        ovf_o;

    spi_tx_unpacker #(.WORD_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .dsize_i     (dsize_i),
        .lsb_i       (lsb_i),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .wr_data_i   (wr_data_i),
        .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i),
        .byte_data_o (byte_data_o),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bytes still owed to the FIFO, in emission order.
    logic [7:0] pend[$];
    logic       exp_ovf = 1'b0;
    logic       idle_zero = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic r, input logic f, input logic [1:0] ds, input logic l,
                        input logic wv, input logic [31:0] wd, input logic br);
        logic exp_ready;
        int   n;
        @(negedge clk);
        rst_n_i = r; flush_i = f; dsize_i = ds; lsb_i = l;
        wr_valid_i = wv; wr_data_i = wd; byte_ready_i = br;
        #1;
        exp_ready = !f && (pend.size() == 0 || (pend.size() == 1 && br));
        chk("valid", byte_valid_o, pend.size() != 0);
        chk("busy", busy_o, pend.size() != 0);
        chk("ready", wr_ready_o, exp_ready);
        chk("ovf", ovf_o, exp_ovf);
        if (pend.size() != 0) chk("data", byte_data_o, pend[0]);
        else if (idle_zero) chk("data_idle", byte_data_o, 8'h00);
        @(posedge clk);
        if (!r) begin
            pend.delete(); exp_ovf = 1'b0; idle_zero = 1'b1;
        end else if (f) begin
            pend.delete(); exp_ovf = 1'b0; idle_zero = 1'b1;
        end else begin
            if (pend.size() != 0 && br) void'(pend.pop_front());
            exp_ovf = wv && !exp_ready;
            if (wv && exp_ready) begin
                n = int'(ds) + 1;
                for (int k = 0; k < n; k++)
                    pend.push_back(wd[8*(l ? k : n-1-k) +: 8]);
                idle_zero = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 2'b00, 0, 0, 32'h0, 1);
    endtask

    initial begin
        // Two reset edges before the model is trusted.
        @(posedge clk); @(posedge clk);
        step(0, 0, 2'b00, 0, 0, 32'h0, 1);
        idle_cycles(1);

        // Ordering, both byte orders
        step(1, 0, 2'b11, 0, 1, 32'hA1B2C3D4, 1); idle_cycles(5);
        step(1, 0, 2'b11, 1, 1, 32'hA1B2C3D4, 1); idle_cycles(5);
        // Sizes
        step(1, 0, 2'b01, 0, 1, 32'hFFFF1234, 1); idle_cycles(3);
        step(1, 0, 2'b10, 1, 1, 32'h00563412, 1); idle_cycles(4);
        step(1, 0, 2'b00, 0, 1, 32'h000000EE, 1); idle_cycles(2);

        // Backpressure after the 2nd byte, then back-to-back second word
        step(1, 0, 2'b11, 0, 1, 32'h11223344, 1);
        step(1, 0, 2'b11, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 0, 32'h0, 0);
        step(1, 0, 2'b11, 0, 0, 32'h0, 1);
        step(1, 0, 2'b11, 0, 0, 32'h0, 1);
        step(1, 0, 2'b01, 1, 1, 32'h0000BEEF, 1);
        idle_cycles(3);

        // Overflow: write while bytes remain, with a mid-word dsize/lsb change
        step(1, 0, 2'b11, 0, 1, 32'hCAFEF00D, 1);
        step(1, 0, 2'b00, 1, 1, 32'h55555555, 1);
        step(1, 0, 2'b00, 1, 0, 32'h0, 1);
        idle_cycles(3);

        // Flush after the 1st byte
        step(1, 0, 2'b11, 0, 1, 32'hDEADBEEF, 1);
        step(1, 0, 2'b11, 0, 0, 32'h0, 1);
        step(1, 1, 2'b11, 0, 0, 32'h0, 1);
        idle_cycles(3);
        // Reset after the 1st byte
        step(1, 0, 2'b11, 1, 1, 32'h01020304, 1);
        step(1, 0, 2'b11, 0, 0, 32'h0, 1);
        step(0, 0, 2'b11, 0, 0, 32'h0, 1);
        idle_cycles(3);
        // Flush coincident with a write
        step(1, 1, 2'b11, 0, 1, 32'h77777777, 1);
        idle_cycles(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 39) == 0,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 4,
                 32'($urandom()),
                 $urandom_range(0, 9) < 7);
        end
        idle_cycles(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_tx_unpacker.md
# spi_tx_unpacker

- Converts 32-bit words written to the SPI transmit data register into a byte stream for the 8-bit TX FIFO push port.
- Lets software issue one TXR write per 8/16/24/32-bit data unit instead of one write per byte.
- Placement: between the APB4 write decode and the TX FIFO push side, directly upstream of the TX FIFO that feeds the SPI shift core.

## Interface
- `WORD_WIDTH`, 32, input word width; only 32 is supported.
- `clk_i`  in  1  APB clock (pclk).
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  synchronous flush; tied to ~ctrl.en.
- `dsize_i`  in  2  data unit size: 00=8, 01=16, 10=24, 11=32 bits.
- `lsb_i`  in  1  1: least-significant byte first; 0: most-significant byte of the unit first.
- `wr_valid_i`  in  1  TXR write strobe.
- `wr_ready_o`  out  1  word can be accepted this cycle.
- `wr_data_i`  in  32  write data; the unit occupies bits [8*N-1:0].
- `byte_valid_o`  out  1  byte available to TX FIFO.
- `byte_ready_i`  in  1  TX FIFO not full.
- `byte_data_o`  out  8  byte to push.
- `busy_o`  out  1  word held, bytes still pending.
- `ovf_o`  out  1  one-cycle pulse: write dropped (`wr_valid_i` && ~`wr_ready_o`).

## Operation
- States:
  - IDLE: nothing held.
  - SEND: holding register `word_q[31:0]` and remaining-byte counter `rem_q[1:0]` (bytes left minus 1) are valid.
- Accept: `wr_valid_i && wr_ready_o` with ~`flush_i`.
  - Loads `word_q` with the unit, aligned so `byte_data_o` is its first byte:
    - `lsb_i`=1: `wr_data_i` unchanged.
    - `lsb_i`=0: unit left-justified into [31:0], first byte in [31:24].
  - Loads `rem_q` = `dsize_i`.
  - `lsb_i` mode is latched as `lsb_q`; state goes to SEND.
  - `dsize_i` and `lsb_i` are sampled only at accept; changes mid-word have no effect.
- `byte_data_o`: `word_q[7:0]` if `lsb_q`, else `word_q[31:24]`.
- Byte handshake in SEND: `byte_valid_o && byte_ready_i` (byte taken).
  - `rem_q` != 0: shift `word_q` by 8 toward the output byte (right if `lsb_q`, left otherwise, zero fill) and decrement `rem_q`.
  - `rem_q` == 0: return to IDLE, unless a new word is accepted in the same cycle, in which case reload and stay in SEND.
- `wr_ready_o` = (state==IDLE) || (`byte_valid_o` && `byte_ready_i` && `rem_q`==0).
  - Combinational from `byte_ready_i`.
  - Forced 0 while `flush_i`=1.
- Dropped writes: with ~`wr_ready_o` a `wr_valid_i` is discarded and `ovf_o` pulses next cycle. The APB bus has no wait states, so software checks stat.txfull/busy.
- `byte_valid_o` = (state==SEND); `busy_o` = (state==SEND).
- Flush: highest priority. Next state IDLE, `word_q`/`rem_q` cleared, any concurrent write dropped without `ovf_o`.

## Timing
- Reset values (after a clock edge with `rst_n_i`=0): IDLE; `word_q`=0, `rem_q`=0; `byte_valid_o`=0, `busy_o`=0, `ovf_o`=0, `byte_data_o`=0; `wr_ready_o`=1 (when `flush_i`=0).
- Reset mid-word: remaining bytes are lost; no byte is emitted after the reset edge.
- Latency: word accepted at edge N gives `byte_valid_o`=1 from cycle N+1.
- Throughput: a unit of N bytes occupies exactly N cycles when `byte_ready_i` stays high. Back-to-back words have no bubble; the last byte and the next accept share one cycle.
- Backpressure: with `byte_ready_i`=0, `byte_data_o`, `word_q` and `rem_q` hold stable, and `byte_valid_o` stays 1 (no retraction).
- `ovf_o` is registered: one pulse per dropped write.

## Structure
- Size encodings `SPI_TRANS_8_BITS`=2'b00, `SPI_TRANS_16_BITS`=2'b01, `SPI_TRANS_24_BITS`=2'b10, `SPI_TRANS_32_BITS`=2'b11 belong in the shared `spi_define.sv`.
- State encoding is local to the module.
- Single flat module: holding register, counter and FSM. No sub-module.
- Registers use the shared `dffr`/`dffer` primitives from `register.sv`.
- The top replaces the direct TXR-to-FIFO push with this block:
  - `byte_ready_i` = ~tx_full.
  - `byte_valid_o` drives the FIFO push.
  - `ovf_o` may be exposed in stat.

## Test plan
- Ordering: dsize=11, lsb=0, write 0xA1B2C3D4 with `byte_ready_i`=1 -> bytes A1,B2,C3,D4 on cycles N+1..N+4, then `busy_o`=0. Same word with lsb=1 -> D4,C3,B2,A1.
- Sizes:
  - dsize=01, lsb=0, write 0xFFFF1234 -> 12,34.
  - dsize=10, lsb=1, write 0x00563412 -> 12,34,56.
  - dsize=00, write 0x000000EE -> EE only.
- Backpressure and no bubble: 32-bit word, hold `byte_ready_i`=0 for 3 cycles after the 2nd byte.
  - `byte_data_o` holds the 2nd byte while `byte_ready_i`=0.
  - A second word presented during the last-byte handshake is accepted with no idle cycle.
- Overflow: write during SEND with `rem_q`!=0 -> `wr_ready_o`=0, `ovf_o` pulses one cycle later, and the byte stream is unaltered.
- Flush/reset mid-word:
  - Assert `flush_i` after the 1st of 4 bytes -> IDLE next cycle, no further bytes.
  - Same with `rst_n_i`=0 for one cycle -> all outputs at reset values.
  - Flush coincident with a write -> write dropped, `ovf_o`=0.
